uart_regfile_n: RTL
===================

# uart_regfile_n

Parametrised host-side register file for a bank of NUM_CH UART channels, the successor to the fixed six-channel map. It decodes a word-addressed bus into per-channel CR/SR/TDR/RDR windows and drives one-cycle access strobes to each UART core. It adds registered reads with a valid/error flag, self-clearing reset bits, and a global sticky interrupt block with mask and write-one-to-clear. It sits between the processor bus bridge and the UART channel instances.

## Interface
- NUM_CH, 6: number of UART channels, 1..32
- DATA_W, 32: register width
- ADDR_W, 22: word address width
- EV_W, 4: interrupt event bits per channel; NUM_CH*EV_W ≤ DATA_W
- CR_RESET, 32'h0000c000: reset value of every CR
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  word address
- we  in  1  write request, single cycle
- re  in  1  read request, single cycle
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid when rd_valid
- rd_valid  out  1  read response, one cycle after re
- rd_err  out  1  with rd_valid: address unmapped
- cr_o  out  NUM_CH*DATA_W  CR of channel n at slice n
- tdr_o  out  NUM_CH*DATA_W  TDR of channel n
- sr_i  in  NUM_CH*DATA_W  status of channel n
- rdr_i  in  NUM_CH*DATA_W  receive data of channel n
- tx_write  out  NUM_CH  pulse: TDR n written
- rx_read  out  NUM_CH  pulse: RDR n read
- sr_read  out  NUM_CH  pulse: SR n read
- ev_i  in  NUM_CH*EV_W  per-channel event pulses
- irq  out  1  OR of pending & mask

## Operation
- Map: channel n at addr 4n+{0 CR, 1 SR, 2 TDR, 3 RDR}. IRQ_PEND at 4*NUM_CH, IRQ_MASK at 4*NUM_CH+1. Everything else is unmapped.
- Writes: CR, TDR, and IRQ_MASK take wdata at the edge. IRQ_PEND is W1C. Writes to SR, RDR, or unmapped addresses are ignored, with no error.
- Strobes: tx_write[n] = we & addr==TDRn; rx_read[n], sr_read[n] = re & address match. Strobes are combinational in the request cycle and forced to 0 while rst.
- Self-clear: if CR bit CR_RX_RESET or CR_TX_RESET is 1, it is cleared on the next edge, so it stays high exactly one cycle. A bus write to that CR in the same cycle wins.
- Pending: pend bit n*EV_W+k is set by ev_i. On a simultaneous set and W1C of the same bit, set wins. Bits above NUM_CH*EV_W read 0.
- Interrupt: irq = |(pend & mask), registered.
- Read: rdata/rd_valid/rd_err are registered. An unmapped read returns 0 with rd_err=1. When re is low, rdata holds its last value and rd_valid=0.
- Same-cycle we and re: both are performed, and the read returns the pre-write value.

## Timing
- Reset values: cr_o=CR_RESET for every channel; tdr_o=0; pend=0; mask=0; irq=0; rdata=0; rd_valid=0; rd_err=0; strobes 0.
- Read latency is 1: re at cycle T gives rd_valid at T+1. SR/RDR are sampled at edge T, in the same cycle as the sr_read/rx_read pulse.
- Write latency is 1: cr_o/tdr_o update at edge T. tx_write is high during T, so the core must sample tdr_o from T+1, or wdata in T.
- Back-to-back reads every cycle are supported, with no stall.
- irq follows a pend/mask change by 1 cycle, so an event at T gives irq at T+2.
- rst asserted mid-read: rd_valid is 0 in the following cycle and the response is dropped.

## Structure
- Package uart_regfile_pkg holds:
  - offset constants OFS_CR/SR/TDR/RDR;
  - CR_RX_RESET/CR_TX_RESET bit indices;
  - IRQ_PEND_OFS/IRQ_MASK_OFS;
  - the CR_RESET default.
- One natural sub-module, uart_ch_regs, is generated per channel. It holds CR, TDR, the self-clear logic and the strobes. The top holds the decode, the read mux/pipeline and the IRQ block.

## Test plan
- Reset, then read CR2 (addr 8) -> rd_valid next cycle with rdata=32'h0000c000 and rd_err=0.
- Write TDR3 (addr 14) = 32'h41 -> tx_write[3] high for 1 cycle, tdr_o slice 3 = 32'h41 from the next cycle; other strobes stay 0.
- Write CR0 with the CR_RX_RESET bit set -> the bit reads 1 for exactly one cycle, then 0; other CR bits are retained.
- Pulse ev_i bit 5 (channel 1, bit 1), then mask=32'h20 -> irq=1. W1C IRQ_PEND with 32'h20 in the same cycle as a new ev pulse -> bit stays 1.
- Read addr 4*NUM_CH+7 -> rdata=0 and rd_err=1. Read RDR5 (addr 23) -> rx_read[5] pulse and rdata=rdr_i slice 5 one cycle later.
- Issue back-to-back reads of SR0, SR1, SR2 -> three consecutive rd_valid cycles with matching data; assert rst in the second cycle -> no third response.

Source files
------------

// File: rtl/uart_regfile_pkg.sv
// Shared register-map constants for the parametrised UART channel register file.
package uart_regfile_pkg;

  // Word offsets inside a channel's four-word window
  localparam logic [1:0] OFS_CR  = 2'd0;
  localparam logic [1:0] OFS_SR  = 2'd1;
  localparam logic [1:0] OFS_TDR = 2'd2;
  localparam logic [1:0] OFS_RDR = 2'd3;

  // Self-clearing CR bits
  localparam int unsigned CR_TX_RESET = 0;
  localparam int unsigned CR_RX_RESET = 1;

  // Interrupt block, relative to the first word past the channel windows
  localparam int unsigned IRQ_PEND_OFS = 0;
  localparam int unsigned IRQ_MASK_OFS = 1;

  localparam logic [31:0] CR_RESET_DEFAULT = 32'h0000_c000;

endpackage

// File: rtl/uart_ch_regs.sv
// Per-channel CR/TDR storage with self-clearing reset bits and bus access strobes.
module uart_ch_regs
  import uart_regfile_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  CR_RESET = DATA_W'(CR_RESET_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [1:0]        ofs,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] tdr,
  output logic              tx_write,
  output logic              rx_read,
  output logic              sr_read
);

  logic [DATA_W-1:0] cr_q, cr_d, tdr_q;
  logic              wr_cr, wr_tdr;

  assign wr_cr  = we & sel & (ofs == OFS_CR);
  assign wr_tdr = we & sel & (ofs == OFS_TDR);

  // Reset bits drop after one cycle; a bus write in the same cycle overrides.
  always_comb begin
    cr_d              = cr_q;
    cr_d[CR_RX_RESET] = 1'b0;
    cr_d[CR_TX_RESET] = 1'b0;
    if (wr_cr) begin
      cr_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q  <= CR_RESET;
      tdr_q <= '0;
    end else begin
      cr_q <= cr_d;
      if (wr_tdr) begin
        tdr_q <= wdata;
      end
    end
  end

  assign cr       = cr_q;
  assign tdr      = tdr_q;
  assign tx_write = ~rst & wr_tdr;
  assign rx_read  = ~rst & re & sel & (ofs == OFS_RDR);
  assign sr_read  = ~rst & re & sel & (ofs == OFS_SR);

endmodule

// File: rtl/uart_regfile_n.sv
// Host register file for NUM_CH UART channels: address decode, registered reads
// and a sticky, maskable, write-one-to-clear interrupt block.
module uart_regfile_n
  import uart_regfile_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 6,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 22,
  parameter int unsigned       EV_W     = 4,
  parameter logic [DATA_W-1:0] CR_RESET = DATA_W'(CR_RESET_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [NUM_CH*DATA_W-1:0] cr_o,
  output logic [NUM_CH*DATA_W-1:0] tdr_o,
  input  logic [NUM_CH*DATA_W-1:0] sr_i,
  input  logic [NUM_CH*DATA_W-1:0] rdr_i,
  output logic [NUM_CH-1:0]        tx_write,
  output logic [NUM_CH-1:0]        rx_read,
  output logic [NUM_CH-1:0]        sr_read,
  input  logic [NUM_CH*EV_W-1:0]   ev_i,
  output logic                     irq
);

  localparam int unsigned       EVT       = NUM_CH * EV_W;
  localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(4 * NUM_CH + IRQ_PEND_OFS);
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(4 * NUM_CH + IRQ_MASK_OFS);

  logic [1:0]        ofs;
  logic [NUM_CH-1:0] sel;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_err_q, rd_err_d;
  logic [EVT-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0] mask_q;
  logic              irq_q;

  assign ofs = addr[1:0];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign sel[n] = (addr[ADDR_W-1:2] == (ADDR_W-2)'(n));

    uart_ch_regs #(
      .DATA_W   (DATA_W),
      .CR_RESET (CR_RESET)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel[n]),
      .ofs      (ofs),
      .we       (we),
      .re       (re),
      .wdata    (wdata),
      .cr       (cr_o[n*DATA_W +: DATA_W]),
      .tdr      (tdr_o[n*DATA_W +: DATA_W]),
      .tx_write (tx_write[n]),
      .rx_read  (rx_read[n]),
      .sr_read  (sr_read[n])
    );
  end

  // Read mux samples pre-write state; rdata holds when no read is issued.
  always_comb begin
    rdata_d  = rdata_q;
    rd_err_d = 1'b0;
    if (re) begin
      rdata_d  = '0;
      rd_err_d = 1'b1;
      for (int n = 0; n < NUM_CH; n++) begin
        if (sel[n]) begin
          rd_err_d = 1'b0;
          case (ofs)
            OFS_CR:  rdata_d = cr_o[n*DATA_W +: DATA_W];
            OFS_SR:  rdata_d = sr_i[n*DATA_W +: DATA_W];
            OFS_TDR: rdata_d = tdr_o[n*DATA_W +: DATA_W];
            default: rdata_d = rdr_i[n*DATA_W +: DATA_W];
          endcase
        end
      end
      if (addr == PEND_ADDR) begin
        rdata_d  = DATA_W'(pend_q);
        rd_err_d = 1'b0;
      end
      if (addr == MASK_ADDR) begin
        rdata_d  = mask_q;
        rd_err_d = 1'b0;
      end
    end
  end

  // New events beat a same-cycle clear of the same bit.
  always_comb begin
    pend_d = pend_q;
    if (we && addr == PEND_ADDR) begin
      pend_d = pend_q & ~wdata[EVT-1:0];
    end
    pend_d = pend_d | ev_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      pend_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= re;
      rd_err_q   <= rd_err_d;
      pend_q     <= pend_d;
      irq_q      <= |(pend_q & mask_q[EVT-1:0]);
      if (we && addr == MASK_ADDR) begin
        mask_q <= wdata;
      end
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign irq      = irq_q;

endmodule
